// File: rtl/xbus_arbiter.sv
// xbus_arbiter: two-master round-robin bus arbiter with registered grant and burst limit
//   clk, rst_n                          clock, async active-low reset
//   m0_*/m1_* req,addr,we,wdata -> ack,rdata   master request/response ports
//   bus_sel,bus_addr,bus_we,bus_wdata <- bus_rdata  muxed decoder access
//   gnt                                 one-hot current owner, 00 when idle
module xbus_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_we,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [1:0]        gnt
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, state_nx;
  logic last_gnt;
  logic [7:0] burst_cnt;
  logic acc0, acc1, at_limit;
  assign acc0 = state == GNT0 && m0_req;
  assign acc1 = state == GNT1 && m1_req;
  // >= rather than == so an owner that ran past the limit alone still yields once the other asks
  assign at_limit = burst_cnt >= 8'(MAX_BURST - 1);
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE)
      state_nx = m0_req && m1_req ? (last_gnt ? GNT0 : GNT1) : m0_req ? GNT0 : m1_req ? GNT1 : IDLE;
    else if (state == GNT0)
      state_nx = !m0_req ? (m1_req ? GNT1 : IDLE) : (at_limit && m1_req) ? GNT1 : GNT0;
    else if (state == GNT1)
      state_nx = !m1_req ? (m0_req ? GNT0 : IDLE) : (at_limit && m0_req) ? GNT0 : GNT1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      burst_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state && state_nx != IDLE) begin
        last_gnt  <= state_nx == GNT1;
        burst_cnt <= '0;
      end else if ((acc0 || acc1) && burst_cnt != 8'hFF) begin
        burst_cnt <= burst_cnt + 8'd1;
      end
    end
  assign gnt       = {state == GNT1, state == GNT0};
  assign bus_sel   = acc0 | acc1;
  assign bus_addr  = acc0 ? m0_addr : acc1 ? m1_addr : '0;
  assign bus_we    = acc0 ? m0_we : acc1 ? m1_we : 1'b0;
  assign bus_wdata = acc0 ? m0_wdata : acc1 ? m1_wdata : '0;
  assign m0_ack    = acc0;
  assign m1_ack    = acc1;
  assign m0_rdata  = acc0 ? bus_rdata : '0;
  assign m1_rdata  = acc1 ? bus_rdata : '0;
endmodule

// File: tb/tb_xbus_arbiter.sv
// tb_xbus_arbiter: directed self-checking bench for xbus_arbiter
module tb_xbus_arbiter;
  logic clk = 0, rst_n = 0;
  logic m0_req = 0, m1_req = 0, m0_we = 0, m1_we = 0;
  logic [11:0] m0_addr = 0, m1_addr = 0, bus_addr, b_addr;
  logic [31:0] m0_wdata = 0, m1_wdata = 0, bus_rdata = 0, bus_wdata, b_wdata;
  logic [31:0] m0_rdata, m1_rdata, b_m0_rdata, b_m1_rdata;
  logic m0_ack, m1_ack, bus_sel, bus_we, b_m0_ack, b_m1_ack, b_sel, b_we;
  logic [1:0] gnt, b_gnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  xbus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_sel(bus_sel), .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .gnt(gnt)
  );
  xbus_arbiter #(.MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .bus_sel(b_sel), .bus_addr(b_addr), .bus_we(b_we), .bus_wdata(b_wdata), .bus_rdata(bus_rdata), .gnt(b_gnt)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 0;
    {m0_req, m1_req, m0_we, m1_we} = '0;
    tick;
    rst_n = 1;
    #1;
  endtask
  task automatic test_reset;
    rst_n = 0;
    m0_req = 1;
    tick;
    checks++;
    if ({gnt, bus_sel, m0_ack, m1_ack} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 00000", {gnt, bus_sel, m0_ack, m1_ack});
    end
    m0_req = 0;
    rst_n = 1;
    #1;
  endtask
  task automatic test_read;
    do_reset;
    m0_req = 1; m0_addr = 12'h010; m0_we = 0; bus_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({m0_ack, bus_sel} !== 2'b00) begin
      errors++;
      $display("FAIL read_idle_noack got %b expected 00", {m0_ack, bus_sel});
    end
    tick;
    checks++;
    if ({m0_ack, m0_rdata, gnt} !== {1'b1, 32'hDEADBEEF, 2'b01}) begin
      errors++;
      $display("FAIL read_ack got ack=%b rdata=%h gnt=%b expected 1 deadbeef 01", m0_ack, m0_rdata, gnt);
    end
    checks++;
    if ({bus_sel, bus_we, bus_addr} !== {1'b1, 1'b0, 12'h010}) begin
      errors++;
      $display("FAIL read_bus got sel=%b we=%b addr=%h expected 1 0 010", bus_sel, bus_we, bus_addr);
    end
    m0_req = 0;
    #1;
    checks++;
    if ({bus_sel, m0_ack, m0_rdata} !== 34'b0) begin
      errors++;
      $display("FAIL read_drop got sel=%b ack=%b rdata=%h expected 0 0 0", bus_sel, m0_ack, m0_rdata);
    end
    tick;
    checks++;
    if (gnt !== 2'b00) begin
      errors++;
      $display("FAIL read_idle_gnt got %b expected 00", gnt);
    end
  endtask
  task automatic test_tie;
    do_reset;
    m0_req = 1; m1_req = 1;
    tick;
    checks++;
    if ({gnt, m1_ack, m0_ack, m1_rdata} !== {2'b01, 2'b01, 32'h0}) begin
      errors++;
      $display("FAIL tie_first got gnt=%b acks=%b m1_rdata=%h expected 01 01 0", gnt, {m1_ack, m0_ack}, m1_rdata);
    end
    m0_req = 0;
    tick;
    checks++;
    if ({gnt, m1_ack, m0_ack} !== 4'b1010) begin
      errors++;
      $display("FAIL tie_handover got gnt=%b acks=%b expected 10 10", gnt, {m1_ack, m0_ack});
    end
    m1_req = 0;
    tick;
    checks++;
    if (gnt !== 2'b00) begin
      errors++;
      $display("FAIL tie_idle got %b expected 00", gnt);
    end
  endtask
  task automatic test_burst;
    logic [1:0] e8, e1;
    do_reset;
    m0_req = 1; m1_req = 1;
    for (int i = 0; i < 32; i++) begin
      tick;
      e8 = ((i / 8) % 2) ? 2'b10 : 2'b01;
      e1 = (i % 2) ? 2'b10 : 2'b01;
      checks++;
      if ({m1_ack, m0_ack, gnt, bus_sel} !== {e8, e8, 1'b1}) begin
        errors++;
        $display("FAIL burst8 cycle %0d got acks=%b gnt=%b sel=%b expected %b %b 1", i, {m1_ack, m0_ack}, gnt, bus_sel, e8, e8);
      end
      checks++;
      if ({b_m1_ack, b_m0_ack, b_sel} !== {e1, 1'b1}) begin
        errors++;
        $display("FAIL burst1 cycle %0d got acks=%b sel=%b expected %b 1", i, {b_m1_ack, b_m0_ack}, b_sel, e1);
      end
    end
    m0_req = 0; m1_req = 0;
    tick;
  endtask
  task automatic test_solo;
    do_reset;
    m1_req = 1;
    for (int i = 0; i < 20; i++) begin
      tick;
      checks++;
      if ({m1_ack, m0_ack, gnt} !== 4'b1010) begin
        errors++;
        $display("FAIL solo cycle %0d got acks=%b gnt=%b expected 10 10", i, {m1_ack, m0_ack}, gnt);
      end
    end
    m1_req = 0;
    tick;
  endtask
  task automatic test_write;
    m0_req = 1; m0_we = 1; m0_addr = 12'h3FF; m0_wdata = 32'h12345678;
    tick;
    checks++;
    if ({bus_sel, bus_we, bus_addr, bus_wdata, m0_ack} !== {1'b1, 1'b1, 12'h3FF, 32'h12345678, 1'b1}) begin
      errors++;
      $display("FAIL write_bus got sel=%b we=%b addr=%h wdata=%h ack=%b expected 1 1 3ff 12345678 1", bus_sel, bus_we, bus_addr, bus_wdata, m0_ack);
    end
    m0_req = 0;
    tick;
    checks++;
    if ({bus_sel, bus_we, bus_addr, bus_wdata} !== 46'b0) begin
      errors++;
      $display("FAIL write_release got sel=%b we=%b addr=%h wdata=%h expected all 0", bus_sel, bus_we, bus_addr, bus_wdata);
    end
    m0_we = 0;
  endtask
  task automatic test_reset_mid;
    do_reset;
    m0_req = 1;
    tick;
    checks++;
    if (m0_ack !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_ack got %b expected 1", m0_ack);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({gnt, bus_sel, m0_ack, m1_ack} !== 5'b0) begin
      errors++;
      $display("FAIL mid_async got %b expected 00000", {gnt, bus_sel, m0_ack, m1_ack});
    end
    m0_req = 0; m1_req = 1;
    tick;
    rst_n = 1;
    #1;
    checks++;
    if ({m1_ack, gnt} !== 3'b000) begin
      errors++;
      $display("FAIL mid_release got ack=%b gnt=%b expected 0 00", m1_ack, gnt);
    end
    tick;
    checks++;
    if ({m1_ack, m0_ack, gnt} !== 4'b1010) begin
      errors++;
      $display("FAIL mid_resume got acks=%b gnt=%b expected 10 10", {m1_ack, m0_ack}, gnt);
    end
    m1_req = 0;
    tick;
  endtask
  initial begin
    test_reset;
    test_read;
    test_tie;
    test_burst;
    test_solo;
    test_write;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
